tile_accumulator: RTL and testbench
===================================

# tile_accumulator

Multi-channel signed accumulator for the LSTM gate datapath. It sums `NUM_TILES` partial-product tiles per output frame across `NUM_CH` parallel channels, saturating per channel, and holds the finished frame behind a valid/ready handshake until the activation stage consumes it. It sits between the tile MAC array and the activation/state-update logic. It generalises the single-channel free-running adder with:
- a tile count,
- per-channel saturation flags,
- back-pressure.

## Interface
Parameters:
- `IN_W`, 32: signed width of one channel's tile partial sum.
- `ACC_W`, 48: signed accumulator and output width per channel; must be ≥ `IN_W`.
- `NUM_CH`, 4: number of parallel channels.
- `CNT_W`, 8: width of the tile-count configuration.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous abort. Returns the block to IDLE and zeroes the accumulators.
- `start` in 1: begin a frame; sampled in IDLE only.
- `cfg_num_tiles` in `CNT_W`: tiles per frame, latched on `start`. A value of 0 is treated as 1.
- `in_valid` in 1: tile data valid.
- `in_ready` out 1: block accepts a tile this cycle.
- `in_data` in `NUM_CH*IN_W`: packed signed tiles; channel c is at bits [c*IN_W +: IN_W].
- `out_valid` out 1: finished frame available.
- `out_ready` in 1: consumer accepts the frame.
- `out_data` out `NUM_CH*ACC_W`: packed signed sums, using the same packing as `in_data`.
- `out_sat` out `NUM_CH`: per-channel sticky saturation flag for the frame.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, ACCUM, HOLD.
- IDLE
  - `start` latches `cfg_num_tiles` (with 0 mapped to 1), zeroes the tile counter, accumulators and `out_sat`, and moves to ACCUM.
- ACCUM
  - `in_ready`=1.
  - Each cycle with `in_valid && in_ready` is a tile transfer:
    - each channel adds the sign-extended `in_data` slice to its accumulator;
    - the tile counter increments.
  - On the transfer where counter == latched count − 1, the FSM moves to HOLD.
- HOLD
  - `out_valid`=1 and `out_data` is stable.
  - On `out_valid && out_ready`:
    - move to IDLE;
    - if `start` is also high that cycle, move directly to ACCUM with a fresh latch and cleared accumulators.
- Arithmetic:
  - Compute the sum in `ACC_W+1` bits.
  - Above 2^(ACC_W−1)−1, clamp to the maximum and set `out_sat[c]`.
  - Below −2^(ACC_W−1), clamp to the minimum and set `out_sat[c]`.
  - A clamped accumulator keeps accumulating from its clamped value.
  - Flags are sticky until the next `start`, `clear` or `rst`.
- `start` outside IDLE (other than the HOLD handshake case) is ignored.
- `in_valid` outside ACCUM is ignored; no data is consumed.
- Priority: `rst` > `clear` > handshake/`start` > tile accumulation.
- `clear` in any state forces IDLE in the next cycle and zeroes the accumulators and `out_sat`.

## Timing
- Reset values: state IDLE; `in_ready`=0, `out_valid`=0, `out_data`=0, `out_sat`=0, `busy`=0. The latched count and tile counter are 0.
- `start` at edge t gives `in_ready`=1 from cycle t+1.
- Throughput is one tile per cycle with no bubbles.
- Last tile transferred at edge t gives `out_valid`=1 and the final `out_data` from cycle t+1. `in_ready` is 0 in that same cycle.
- Frame latency from `start` with N tiles and no stalls: `out_valid` is high N+1 cycles after `start`.
- `out_data` and `out_sat` stay constant while `out_valid`=1 and `out_ready`=0.
- `rst` or `clear` during ACCUM or HOLD discards the partial or finished frame. No `out_valid` pulse follows.

## Structure
- Shared package `lstm_acc_pkg` holds:
  - the FSM state enum (IDLE/ACCUM/HOLD);
  - the `sat_add` function or width constants;
  - the default `IN_W`/`ACC_W`/`NUM_CH` values.
- One natural sub-module is `sat_acc_lane`: one channel's accumulator register, saturating adder and sticky flag. It is instantiated `NUM_CH` times under generate.
- The FSM and tile counter live in the top level.

## Test plan
- **Basic frame:** `NUM_CH`=4, `cfg_num_tiles`=3, tiles {1,2,3,4}, {10,20,30,40}, {−1,−2,−3,−4} on consecutive cycles → `out_valid` one cycle after the third tile; `out_data`={10,20,30,40}; `out_sat`=0.
- **Stalls and back-pressure:**
  - `in_valid` toggles 1,0,1,0,1 with 3 tiles of value 5 → the sum is 15 after the 3rd transfer.
  - Hold `out_ready`=0 for 4 cycles → `out_data` is stable and `in_ready`=0 throughout.
- **Saturation:** `ACC_W`=`IN_W`=8, tiles 100, 100, −50 on channel 0 → result 77 (127 − 50); `out_sat[0]`=1; other channels' flags 0. Negative case: tiles −100, −100 → result −128 with the flag set.
- **Zero count and back-to-back:**
  - `cfg_num_tiles`=0 → the frame completes after 1 tile.
  - `start` asserted in the same cycle as the output handshake → the next frame begins with zeroed accumulators; no idle cycle.
- **Abort:** `clear` after 2 of 5 tiles → IDLE next cycle, `busy`=0, no `out_valid`. A following frame of 1 tile of 7 → output 7 (no residue).
- **Reset mid-HOLD:** `rst` while `out_valid`=1 → `out_valid`=0, `out_data`=0, `out_sat`=0 next cycle; `start` and `in_valid` are ignored while `rst` is high.

Source files
------------

// File: rtl/lstm_acc_pkg.sv
// rtl/lstm_acc_pkg.sv - shared types and defaults for the LSTM tile accumulator
package lstm_acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } acc_state_e;

  localparam int DEF_IN_W   = 32;
  localparam int DEF_ACC_W  = 48;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/sat_acc_lane.sv
// rtl/sat_acc_lane.sv - one channel: saturating accumulator register with sticky flag
module sat_acc_lane #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [IN_W-1:0]  din,
  output logic [ACC_W-1:0] acc,
  output logic             sat
);

  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] sum_sat;
  logic             ovf;

  // One guard bit is enough: the two top bits disagree exactly when the sum leaves range.
  always_comb begin
    sum     = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){din[IN_W-1]}}, din};
    ovf     = sum[ACC_W] ^ sum[ACC_W-1];
    sum_sat = sum[ACC_W-1:0];
    if (ovf) begin
      sum_sat = sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      sat <= 1'b0;
    end else if (add_en) begin
      acc <= sum_sat;
      sat <= sat | ovf;
    end
  end

endmodule

// File: rtl/tile_accumulator.sv
// rtl/tile_accumulator.sv - multi-channel saturating tile accumulator with output handshake
module tile_accumulator
  import lstm_acc_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    start,
  input  logic [CNT_W-1:0]        cfg_num_tiles,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*ACC_W-1:0] out_data,
  output logic [NUM_CH-1:0]       out_sat,
  output logic                    busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  acc_state_e       state, state_nxt;
  logic [CNT_W-1:0] count_lat;
  logic [CNT_W-1:0] tile_cnt;
  logic             start_fire;
  logic             xfer;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_HOLD);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_nxt  = state;
    start_fire = 1'b0;
    xfer       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt  = ST_ACCUM;
          start_fire = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          xfer = 1'b1;
          if (tile_cnt == count_lat - CNT_ONE) begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_nxt = ST_IDLE;
          if (start) begin
            state_nxt  = ST_ACCUM;
            start_fire = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Abort overrides everything except reset, which the registers handle directly.
    if (clear) begin
      state_nxt  = ST_IDLE;
      start_fire = 1'b0;
      xfer       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count_lat <= '0;
      tile_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        tile_cnt <= '0;
      end else if (start_fire) begin
        count_lat <= (cfg_num_tiles == '0) ? CNT_ONE : cfg_num_tiles;
        tile_cnt  <= '0;
      end else if (xfer) begin
        tile_cnt <= tile_cnt + CNT_ONE;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    sat_acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clr    (clear | start_fire),
      .add_en (xfer),
      .din    (in_data[c*IN_W +: IN_W]),
      .acc    (out_data[c*ACC_W +: ACC_W]),
      .sat    (out_sat[c])
    );
  end

endmodule

// File: tb/tb_tile_accumulator.sv
// tb/tb_tile_accumulator.sv - scoreboard bench for tile_accumulator
module tb_tile_accumulator;

  typedef struct {
    logic [191:0] data;
    logic [3:0]   sat;
  } a_exp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  sat;
  } b_exp_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Wide instance: IN_W=32, ACC_W=48
  logic         a_clear, a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [7:0]   a_cfg;
  logic [127:0] a_in_data;
  logic [191:0] a_out_data;
  logic [3:0]   a_out_sat;

  // Narrow instance: IN_W=ACC_W=8 for saturation corners
  logic         b_clear, b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [7:0]   b_cfg;
  logic [31:0]  b_in_data;
  logic [31:0]  b_out_data;
  logic [3:0]   b_out_sat;

  tile_accumulator #(.IN_W(32), .ACC_W(48), .NUM_CH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .clear(a_clear), .start(a_start), .cfg_num_tiles(a_cfg),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_sat(a_out_sat), .busy(a_busy)
  );

  tile_accumulator #(.IN_W(8), .ACC_W(8), .NUM_CH(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .clear(b_clear), .start(b_start), .cfg_num_tiles(b_cfg),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_sat(b_out_sat), .busy(b_busy)
  );

  a_exp_t a_q[$];
  b_exp_t b_q[$];
  a_exp_t a_e;
  b_exp_t b_e;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pk32(input int c0, input int c1, input int c2, input int c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [191:0] pk48(input longint c0, input longint c1, input longint c2, input longint c3);
    return {c3[47:0], c2[47:0], c1[47:0], c0[47:0]};
  endfunction

  function automatic logic [31:0] pk8(input int c0, input int c1, input int c2, input int c3);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_begin(input logic [7:0] n);
    a_cfg = n; a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic a_tile(input logic [127:0] d);
    a_in_valid = 1'b1; a_in_data = d;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic b_begin(input logic [7:0] n);
    b_cfg = n; b_start = 1'b1;
    tick();
    b_start = 1'b0;
  endtask

  task automatic b_tile(input logic [31:0] d);
    b_in_valid = 1'b1; b_in_data = d;
    tick();
    b_in_valid = 1'b0;
  endtask

  // Monitors: compare against the scoreboard whenever a frame handshake is presented.
  always @(negedge clk) begin
    if (a_out_valid && a_out_ready) begin
      if (a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_frame: got data %0h expected no frame", a_out_data);
      end else begin
        a_e = a_q.pop_front();
        chk("a_frame_data", a_out_data, a_e.data);
        chk("a_frame_sat", 192'(a_out_sat), 192'(a_e.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (b_out_valid && b_out_ready) begin
      if (b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_frame: got data %0h expected no frame", b_out_data);
      end else begin
        b_e = b_q.pop_front();
        chk("b_frame_data", 192'(b_out_data), 192'(b_e.data));
        chk("b_frame_sat", 192'(b_out_sat), 192'(b_e.sat));
      end
    end
  end

  initial begin
    rst = 1'b1;
    a_clear = 0; a_start = 0; a_cfg = 0; a_in_valid = 0; a_in_data = '0; a_out_ready = 0;
    b_clear = 0; b_start = 0; b_cfg = 0; b_in_valid = 0; b_in_data = '0; b_out_ready = 0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_in_ready", 192'(a_in_ready), 192'(0));
    chk("rst_out_valid", 192'(a_out_valid), 192'(0));
    chk("rst_out_data", a_out_data, 192'(0));
    chk("rst_out_sat", 192'(a_out_sat), 192'(0));
    chk("rst_busy", 192'(a_busy), 192'(0));
    chk("rst_b_out_data", 192'(b_out_data), 192'(0));

    // Basic frame, consecutive tiles, sign-extended negatives
    a_out_ready = 1'b1;
    a_q.push_back('{pk48(10, 20, 30, 40), 4'b0000});
    a_begin(8'd3);
    chk("basic_in_ready_after_start", 192'(a_in_ready), 192'(1));
    a_tile(pk32(1, 2, 3, 4));
    a_tile(pk32(10, 20, 30, 40));
    a_tile(pk32(-1, -2, -3, -4));
    chk("basic_out_valid_latency", 192'(a_out_valid), 192'(1));
    chk("basic_in_ready_in_hold", 192'(a_in_ready), 192'(0));
    tick();
    chk("basic_idle_after_handshake", 192'(a_busy), 192'(0));

    // Bubbles on input, then back-pressure on output
    a_out_ready = 1'b0;
    a_q.push_back('{pk48(15, 15, 15, 15), 4'b0000});
    a_begin(8'd3);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i % 2 == 0); a_in_data = pk32(5, 5, 5, 5);
      tick();
    end
    a_in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("stall_out_valid", 192'(a_out_valid), 192'(1));
      chk("stall_in_ready", 192'(a_in_ready), 192'(0));
      chk("stall_out_data", a_out_data, pk48(15, 15, 15, 15));
      tick();
    end
    a_out_ready = 1'b1;
    tick();

    // Zero count means one tile; then start on the handshake cycle
    a_q.push_back('{pk48(1, -2, 3, -4), 4'b0000});
    a_begin(8'd0);
    a_tile(pk32(1, -2, 3, -4));
    chk("zero_cnt_out_valid", 192'(a_out_valid), 192'(1));
    a_q.push_back('{pk48(2, 2, 2, 2), 4'b0000});
    a_begin(8'd2);
    chk("b2b_in_ready", 192'(a_in_ready), 192'(1));
    chk("b2b_out_valid_low", 192'(a_out_valid), 192'(0));
    a_tile(pk32(1, 1, 1, 1));
    a_tile(pk32(1, 1, 1, 1));
    chk("b2b_out_valid", 192'(a_out_valid), 192'(1));
    tick();

    // Abort after 2 of 5 tiles, then a clean 1-tile frame
    a_begin(8'd5);
    a_tile(pk32(9, 9, 9, 9));
    a_tile(pk32(9, 9, 9, 9));
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("abort_busy", 192'(a_busy), 192'(0));
    chk("abort_in_ready", 192'(a_in_ready), 192'(0));
    chk("abort_out_data", a_out_data, 192'(0));
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_out_valid", 192'(a_out_valid), 192'(0));
      tick();
    end
    a_q.push_back('{pk48(7, 7, 7, 7), 4'b0000});
    a_begin(8'd1);
    a_tile(pk32(7, 7, 7, 7));
    chk("abort_next_out_valid", 192'(a_out_valid), 192'(1));
    tick();

    // Reset while holding a finished frame; start/in_valid ignored under reset
    a_out_ready = 1'b0;
    a_begin(8'd1);
    a_tile(pk32(3, 3, 3, 3));
    chk("rsthold_out_valid", 192'(a_out_valid), 192'(1));
    rst = 1'b1; a_start = 1'b1; a_in_valid = 1'b1; a_in_data = pk32(6, 6, 6, 6);
    tick();
    chk("rsthold_out_valid_low", 192'(a_out_valid), 192'(0));
    chk("rsthold_out_data", a_out_data, 192'(0));
    chk("rsthold_out_sat", 192'(a_out_sat), 192'(0));
    tick();
    chk("rsthold_busy", 192'(a_busy), 192'(0));
    rst = 1'b0; a_start = 1'b0; a_in_valid = 1'b0;
    tick();
    chk("rsthold_idle_after", 192'(a_busy), 192'(0));
    a_out_ready = 1'b1;

    // Saturation on the narrow instance
    b_out_ready = 1'b1;
    b_q.push_back('{pk8(77, 3, 0, -3), 4'b0001});
    b_begin(8'd3);
    b_tile(pk8(100, 1, 0, -1));
    b_tile(pk8(100, 1, 0, -1));
    b_tile(pk8(-50, 1, 0, -1));
    chk("sat_pos_out_valid", 192'(b_out_valid), 192'(1));
    chk("sat_pos_flag_live", 192'(b_out_sat), 192'(4'b0001));
    tick();
    b_q.push_back('{pk8(-128, 0, 127, -128), 4'b0001});
    b_begin(8'd2);
    b_tile(pk8(-100, 0, 64, -64));
    b_tile(pk8(-100, 0, 63, -64));
    chk("sat_neg_out_valid", 192'(b_out_valid), 192'(1));
    tick();
    tick();

    chk("a_scoreboard_drained", 192'(a_q.size()), 192'(0));
    chk("b_scoreboard_drained", 192'(b_q.size()), 192'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
